// File: rtl/dmem_pkg.sv
// Shared types, defaults and index-width helper for the parametrised data memory.
package dmem_pkg;

    localparam int DMEM_DATA_W_DEF = 32;
    localparam int DMEM_DEPTH_DEF  = 1024;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } dmem_state_t;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_init_seq.sv
// Post-reset sequencer for dmem_param; the zeroing sweep exists only when
// DMEM_ZERO_INIT_EN is defined, otherwise the memory is ready as soon as rst drops.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_INIT | sweeping zeros into mem[initCnt]; user requests ignored
//   ST_RUN  | normal operation; user requests accepted while rst is low
module dmem_init_seq
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    ready,
    output logic                    initWe,
    output logic [idx_w(DEPTH)-1:0] initIdx
);

    localparam int IDX_W = idx_w(DEPTH);

    dmem_state_t state;

`ifdef DMEM_ZERO_INIT_EN
    logic [IDX_W-1:0] initCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_INIT;
            initCnt <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    // The last increment wraps initCnt back to zero on the way to RUN.
                    initCnt <= initCnt + 1'b1;
                    if (initCnt == IDX_W'(DEPTH - 1)) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    assign initWe  = (state == ST_INIT) && !rst;
    assign initIdx = initCnt;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= ST_RUN;
        end
    end

    assign initWe  = 1'b0;
    assign initIdx = '0;
`endif

    assign ready = (state == ST_RUN) && !rst;

endmodule

// File: rtl/dmem_param.sv
// Parametrised byte-maskable single-port data memory with read-valid and
// out-of-range strobes; optional zeroing sweep via DMEM_ZERO_INIT_EN.
module dmem_param
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W_DEF,
    parameter int DEPTH  = DMEM_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              addr,
    input  logic [DATA_W-1:0]        wrData,
    input  logic [DATA_W/8-1:0]      wrMask,
    input  logic                     wrMem,
    input  logic                     rdMem,
    output logic                     ready,
    output logic signed [DATA_W-1:0] rdData,
    output logic                     rdValid,
    output logic                     addrErr
);

    localparam int IDX_W = idx_w(DEPTH);
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              initWe;
    logic [IDX_W-1:0]  initIdx;
    logic [IDX_W-1:0]  idx;
    logic              inRange;
    logic              userRd;
    logic              userReq;
    logic              userWe;
    logic              memWe;
    logic [IDX_W-1:0]  memIdx;
    logic [NB-1:0]     memMask;
    logic [DATA_W-1:0] memWdata;

    dmem_init_seq #(
        .DEPTH (DEPTH)
    ) u_init_seq (
        .clk     (clk),
        .rst     (rst),
        .ready   (ready),
        .initWe  (initWe),
        .initIdx (initIdx)
    );

    assign idx     = addr[IDX_W-1:0];
    assign inRange = (addr[31:IDX_W] == '0);
    assign userRd  = ready && rdMem;
    assign userReq = ready && (wrMem || rdMem);
    assign userWe  = ready && wrMem && inRange;

    // The sweep and user traffic never overlap (ready is low in INIT),
    // so the sequencer simply takes the port while it is active.
    assign memWe    = initWe || userWe;
    assign memIdx   = initWe ? initIdx : idx;
    assign memMask  = initWe ? {NB{1'b1}} : wrMask;
    assign memWdata = initWe ? '0 : wrData;

    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int i = 0; i < NB; i++) begin
                if (memMask[i]) begin
                    mem[memIdx][8*i +: 8] <= memWdata[8*i +: 8];
                end
            end
        end
    end

    // Sampled with non-blocking semantics, so a same-edge write is not seen (read-first).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdData  <= '0;
            rdValid <= 1'b0;
            addrErr <= 1'b0;
        end else begin
            rdValid <= userRd;
            addrErr <= userReq && !inRange;
            if (userRd) begin
                rdData <= inRange ? mem[idx] : '0;
            end
        end
    end

endmodule
